// File: rtl/decode_alu_ctrl_pkg.sv
// Shared constants and types for the decode-stage ALU control block:
// ALU codes, RV32I opcode/funct fields, skid-buffer states and the decoded-entry record.
package decode_alu_ctrl_pkg;

  localparam int INST_W     = 32;
  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_XOR     = 3'b100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_TWO   = 2'b10
  } skid_state_e;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  src_imm;
    logic [INST_W-1:0]     imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  illegal;
  } dec_t;

  localparam dec_t DEC_RESET = '{
    alu_ctrl:  ALU_ADD,
    src_imm:   1'b0,
    imm:       32'h0000_0000,
    rs1:       5'd0,
    rs2:       5'd0,
    rd:        5'd0,
    reg_write: 1'b0,
    illegal:   1'b0
  };

  function automatic logic [INST_W-1:0] sext_i(input logic [11:0] field);
    return {{20{field[11]}}, field};
  endfunction

endpackage

// File: rtl/decode_alu_ctrl_decode.sv
// Combinational RV32I ALU-subset decoder: instruction word -> ALU code, operand
// select, immediate, register indices, write enable and illegal flag.
module alu_ctrl_decode
  import decode_alu_ctrl_pkg::*;
(
  input  logic [INST_W-1:0] instr,
  output dec_t              dec
);

  logic [6:0]            opcode_s;
  logic [2:0]            funct3_s;
  logic [6:0]            funct7_s;
  logic [ALU_CTRL_W-1:0] alu_s;
  logic                  legal_s;
  logic                  is_imm_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];

  // Classify the encoding and pick the ALU operation
  always_comb begin
    alu_s    = ALU_ADD;
    legal_s  = 1'b0;
    is_imm_s = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct3_s)
          F3_ADD_SUB: begin
            if (funct7_s == F7_BASE) begin
              alu_s   = ALU_ADD;
              legal_s = 1'b1;
            end else if (funct7_s == F7_SUB) begin
              alu_s   = ALU_SUB;
              legal_s = 1'b1;
            end else begin
              legal_s = 1'b0;
            end
          end
          F3_AND: begin
            alu_s   = ALU_AND;
            legal_s = (funct7_s == F7_BASE);
          end
          F3_OR: begin
            alu_s   = ALU_OR;
            legal_s = (funct7_s == F7_BASE);
          end
          F3_XOR: begin
            alu_s   = ALU_XOR;
            legal_s = (funct7_s == F7_BASE);
          end
          default: legal_s = 1'b0;
        endcase
      end
      OP_ITYPE: begin
        is_imm_s = 1'b1;
        case (funct3_s)
          F3_ADD_SUB: begin alu_s = ALU_ADD; legal_s = 1'b1; end
          F3_AND:     begin alu_s = ALU_AND; legal_s = 1'b1; end
          F3_OR:      begin alu_s = ALU_OR;  legal_s = 1'b1; end
          F3_XOR:     begin alu_s = ALU_XOR; legal_s = 1'b1; end
          default:    legal_s = 1'b0;
        endcase
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Assemble the decoded entry; illegal encodings keep only the register fields
  always_comb begin
    dec         = DEC_RESET;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.illegal = ~legal_s;
    if (legal_s) begin
      dec.alu_ctrl  = alu_s;
      dec.reg_write = (instr[11:7] != 5'd0);
      if (is_imm_s) begin
        dec.src_imm = 1'b1;
        dec.imm     = sext_i(instr[31:20]);
        dec.rs2     = 5'd0;
      end else begin
        dec.src_imm = 1'b0;
        dec.imm     = 32'h0000_0000;
      end
    end else begin
      dec.alu_ctrl  = ALU_ADD;
      dec.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/decode_alu_ctrl.sv
// Decode-stage ALU control: decoder feeding a 2-entry skid buffer so that the
// ready towards fetch is registered and never depends on the execute-side ready.
module decode_alu_ctrl
  import decode_alu_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_W-1:0]     instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  alu_src_imm,
  output logic [INST_W-1:0]     imm,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic                  reg_write,
  output logic                  illegal
);

  dec_t        dec_s;
  dec_t        main_r;
  dec_t        skid_r;
  skid_state_e state_r;
  skid_state_e state_next_s;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        in_xfer_s;
  logic        out_xfer_s;
  logic        load_main_in_s;
  logic        load_main_skid_s;
  logic        load_skid_s;

  alu_ctrl_decode u_decode (
    .instr (instr),
    .dec   (dec_s)
  );

  // Skid FSM next state and buffer load controls; flush overrides any transfer
  always_comb begin
    in_xfer_s        = in_valid & in_ready_r & ~flush;
    out_xfer_s       = out_valid_r & out_ready & ~flush;
    state_next_s     = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_next_s = SKID_EMPTY;
    end else begin
      case (state_r)
        SKID_EMPTY: begin
          if (in_xfer_s) begin
            state_next_s   = SKID_ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_next_s = SKID_EMPTY;
          end
        end
        SKID_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            state_next_s   = SKID_ONE;
            load_main_in_s = 1'b1;
          end else if (in_xfer_s) begin
            state_next_s = SKID_TWO;
            load_skid_s  = 1'b1;
          end else if (out_xfer_s) begin
            state_next_s = SKID_EMPTY;
          end else begin
            state_next_s = SKID_ONE;
          end
        end
        SKID_TWO: begin
          if (out_xfer_s) begin
            state_next_s     = SKID_ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_next_s = SKID_TWO;
          end
        end
        default: state_next_s = SKID_EMPTY;
      endcase
    end
  end

  // State register with registered handshake flags derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SKID_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s != SKID_TWO);
      out_valid_r <= (state_next_s != SKID_EMPTY);
    end
  end

  // Main (output-facing) and skid entry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= DEC_RESET;
      skid_r <= DEC_RESET;
    end else begin
      if (load_main_in_s) begin
        main_r <= dec_s;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= dec_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign alu_control = main_r.alu_ctrl;
  assign alu_src_imm = main_r.src_imm;
  assign imm         = main_r.imm;
  assign rs1         = main_r.rs1;
  assign rs2         = main_r.rs2;
  assign rd          = main_r.rd;
  assign reg_write   = main_r.reg_write;
  assign illegal     = main_r.illegal;

endmodule

// File: tb/tb_decode_alu_ctrl.sv
// Self-checking bench for decode_alu_ctrl: directed vector table, hand-written
// backpressure/flush/reset sequences, then randomized traffic against a queue model.
module tb_decode_alu_ctrl;
  import decode_alu_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  alu_control;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, illegal;

  int n_cmp = 0;
  int n_fail = 0;

  exp_t act;
  assign act = '{alu: alu_control, src: alu_src_imm, imm: imm, rs1: rs1, rs2: rs2,
                 rd: rd, rw: reg_write, ill: illegal};

  decode_alu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .alu_src_imm(alu_src_imm), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // Reference decoder written from the instruction-set rules
  function automatic exp_t model(input logic [31:0] w);
    exp_t r;
    int op, f3, f7;
    bit legal;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    r = '{alu: ALU_ADD, src: 1'b0, imm: 32'h0, rs1: w[19:15], rs2: w[24:20],
          rd: w[11:7], rw: 1'b0, ill: 1'b1};
    legal = 1'b0;
    if (op == 'h33 && (f7 == 0 || (f7 == 'h20 && f3 == 0)) &&
        (f3 == 0 || f3 == 4 || f3 == 6 || f3 == 7)) legal = 1'b1;
    if (op == 'h13 && (f3 == 0 || f3 == 4 || f3 == 6 || f3 == 7)) legal = 1'b1;
    if (legal) begin
      r.ill = 1'b0;
      r.rw  = (w[11:7] != 5'd0);
      case (f3)
        0: r.alu = (op == 'h33 && f7 == 'h20) ? ALU_SUB : ALU_ADD;
        4: r.alu = ALU_XOR;
        6: r.alu = ALU_OR;
        default: r.alu = ALU_AND;
      endcase
      if (op == 'h13) begin
        r.src = 1'b1;
        r.rs2 = 5'd0;
        r.imm = 32'($signed(w) >>> 20);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: begin
        f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
        w = {f7, w[24:7], 7'b0110011};
      end
      2: w = {w[31:7], 7'b0010011};
      default: w = {7'h00, w[24:15], 3'($urandom_range(4, 7)), w[11:7], 7'b0110011};
    endcase
    return w;
  endfunction

  exp_t RST_EXP;
  exp_t q[$];
  vec_t vecs[10];

  initial begin
    RST_EXP = '{alu: ALU_ADD, src: 1'b0, imm: 32'h0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                rw: 1'b0, ill: 1'b0};
    vecs[0] = '{32'h002081B3, '{ALU_ADD, 1'b0, 32'h0,        5'd1,  5'd2,  5'd3,  1'b1, 1'b0}};
    vecs[1] = '{32'h407302B3, '{ALU_SUB, 1'b0, 32'h0,        5'd6,  5'd7,  5'd5,  1'b1, 1'b0}};
    vecs[2] = '{32'hFFF00093, '{ALU_ADD, 1'b1, 32'hFFFFFFFF, 5'd0,  5'd0,  5'd1,  1'b1, 1'b0}};
    vecs[3] = '{32'h0F024213, '{ALU_XOR, 1'b1, 32'h000000F0, 5'd4,  5'd0,  5'd4,  1'b1, 1'b0}};
    vecs[4] = '{32'h00000000, '{ALU_ADD, 1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  1'b0, 1'b1}};
    vecs[5] = '{32'h00C5F533, '{ALU_AND, 1'b0, 32'h0,        5'd11, 5'd12, 5'd10, 1'b1, 1'b0}};
    vecs[6] = '{32'h0020E033, '{ALU_OR,  1'b0, 32'h0,        5'd1,  5'd2,  5'd0,  1'b0, 1'b0}};
    vecs[7] = '{32'h7FF1F113, '{ALU_AND, 1'b1, 32'h000007FF, 5'd3,  5'd0,  5'd2,  1'b1, 1'b0}};
    vecs[8] = '{32'h40C5F533, '{ALU_ADD, 1'b0, 32'h0,        5'd11, 5'd12, 5'd10, 1'b0, 1'b1}};
    vecs[9] = '{32'h00109093, '{ALU_ADD, 1'b0, 32'h0,        5'd1,  5'd1,  5'd1,  1'b0, 1'b1}};

    // Reset state
    repeat (2) @(negedge clk);
    cmp("rst_out_valid", 64'(out_valid), 64'd0);
    cmp("rst_in_ready", 64'(in_ready), 64'd1);
    cmp("rst_outputs", 64'(act), 64'(RST_EXP));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, back-to-back with OUT_READY=1
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; instr = vecs[i].instr; out_ready = 1'b1;
      @(negedge clk);
      cmp($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      cmp($sformatf("vec%0d_fields", i), 64'(act), 64'(vecs[i].exp));
    end
    in_valid = 1'b0;
    @(negedge clk);
    cmp("vec_drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: A and B accepted, C waits; outputs frozen on A
    out_ready = 1'b0; in_valid = 1'b1; instr = vecs[0].instr;
    @(negedge clk);
    cmp("bp1_in_ready", 64'(in_ready), 64'd1);
    cmp("bp1_a", 64'(act), 64'(vecs[0].exp));
    instr = vecs[1].instr;
    @(negedge clk);
    cmp("bp2_in_ready", 64'(in_ready), 64'd0);
    cmp("bp2_a_held", 64'(act), 64'(vecs[0].exp));
    instr = vecs[2].instr;
    @(negedge clk);
    cmp("bp3_in_ready", 64'(in_ready), 64'd0);
    cmp("bp3_a_held", 64'(act), 64'(vecs[0].exp));
    out_ready = 1'b1;
    @(negedge clk);
    cmp("bp4_valid", 64'(out_valid), 64'd1);
    cmp("bp4_b", 64'(act), 64'(vecs[1].exp));
    cmp("bp4_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    cmp("bp5_c", 64'(act), 64'(vecs[2].exp));
    in_valid = 1'b0;
    @(negedge clk);
    cmp("bp6_empty", 64'(out_valid), 64'd0);

    // Flush while holding two entries, with a new instruction presented
    out_ready = 1'b0; in_valid = 1'b1; instr = vecs[0].instr;
    @(negedge clk);
    instr = vecs[1].instr;
    @(negedge clk);
    flush = 1'b1; instr = vecs[3].instr;
    @(negedge clk);
    cmp("fl_two_valid", 64'(out_valid), 64'd0);
    cmp("fl_two_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    cmp("fl_two_no_out", 64'(out_valid), 64'd0);
    // Flush with one entry and IN_READY=1: the presented instruction is dropped
    out_ready = 1'b0; in_valid = 1'b1; instr = vecs[0].instr;
    @(negedge clk);
    cmp("fl_one_filled", 64'(out_valid), 64'd1);
    flush = 1'b1; instr = vecs[3].instr;
    @(negedge clk);
    cmp("fl_one_valid", 64'(out_valid), 64'd0);
    cmp("fl_one_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    cmp("fl_one_no_out", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; instr = vecs[1].instr;
    @(negedge clk);
    instr = vecs[2].instr;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_valid", 64'(out_valid), 64'd0);
    cmp("arst_in_ready", 64'(in_ready), 64'd1);
    cmp("arst_outputs", 64'(act), 64'(RST_EXP));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; instr = vecs[5].instr; out_ready = 1'b1;
    @(negedge clk);
    cmp("arst_first_valid", 64'(out_valid), 64'd1);
    cmp("arst_first_fields", 64'(act), 64'(vecs[5].exp));
    in_valid = 1'b0;
    @(negedge clk);

    // Randomized traffic against a queue model
    for (int c = 0; c < 600; c++) begin
      bit iv, ordy, fl, ix, ox;
      logic [31:0] w;
      cmp("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
      cmp("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) cmp("rnd_fields", 64'(act), 64'(q[0]));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      w    = rand_instr();
      in_valid = iv; out_ready = ordy; flush = fl; instr = w;
      ix = iv && (q.size() < 2) && !fl;
      ox = ordy && (q.size() > 0) && !fl;
      @(posedge clk);
      if (fl) q.delete();
      else begin
        if (ox) void'(q.pop_front());
        if (ix) q.push_back(model(w));
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
